pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline sequencer that drives the PC register's hold_flag, jump_flag and jump_addr inputs.
- Arbitrates stall requests from execute (multi-cycle ops) and the bus (wait states), and jump requests from execute and the trap/interrupt unit.
- Sequences trap entry: accept, drain the pipeline, redirect, then flush.
- Sits between execute, bus interface, trap unit, and the PC/IF/ID/EX stage registers.

Parameters:
ADDR_W, 32, width of jump/trap addresses
FLUSH_CYCLES, 2, cycles after a redirect during which fetched instructions are marked invalid (1..7)
DRAIN_MAX, 15, drain-cycle limit used only by the optional timeout (1..255)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_jump_req  in  1  branch/jump resolved in execute
ex_jump_addr  in  ADDR_W  execute jump target
ex_hold_req  in  1  multi-cycle execute op in progress
bus_hold_req  in  1  bus not ready for fetch/data access
trap_req  in  1  trap/interrupt request, held until trap_ack
trap_addr  in  ADDR_W  handler address, valid with trap_req
trap_ack  out  1  one-cycle acknowledge, coincides with redirect
hold_flag  out  3  0 none, 1 HOLD_PC, 2 HOLD_IF, 3 HOLD_ID (each level freezes PC and all stages up to it)
jump_flag  out  1  redirect PC this cycle
jump_addr  out  ADDR_W  redirect target
flush  out  1  IF/ID contents invalid, insert bubble
drain_timeout  out  1  sticky drain-timeout flag

Behaviour:
- Reset is asynchronous, active-low, on clk; takes effect immediately, including mid-operation.
  - FSM goes to IDLE; flush_cnt=0; drain_cnt=0; latched trap address=0; drain_timeout=0.
  - All outputs 0 while rst_n is low.
- FSM states: IDLE, DRAIN, REDIRECT.
- IDLE:
  - hold_flag = 3 if ex_hold_req, else 1 if bus_hold_req, else 0 (highest level wins).
  - jump_flag = ex_jump_req and jump_addr = ex_jump_addr, combinational, zero latency. jump_addr = 0 when no jump.
  - If trap_req=1: latch trap_addr, clear drain_cnt, next state DRAIN.
  - If ex_jump_req and trap_req fire in the same cycle, the execute jump is issued this cycle and the trap proceeds afterwards.
- DRAIN:
  - hold_flag = 3 unconditionally.
  - ex_jump_req is ignored (jump_flag=0).
  - drain_cnt increments each cycle, saturating.
  - Next state is REDIRECT when ex_hold_req=0 and bus_hold_req=0; otherwise stay in DRAIN.
  - Minimum residency is 1 cycle.
- REDIRECT (exactly 1 cycle):
  - jump_flag=1; jump_addr = latched trap address; trap_ack=1; hold_flag=0.
  - ex_jump_req is ignored.
  - Next state IDLE.
- Trap latency: accept edge → DRAIN (≥1 cycle) → REDIRECT. Minimum is 2 cycles from the trap_req-sampled cycle to jump_flag.
- trap_req is sampled only in IDLE. trap_req high in the IDLE cycle after trap_ack counts as a new request.
- Flush:
  - Any cycle with jump_flag=1 loads flush_cnt=FLUSH_CYCLES on the next edge.
  - Otherwise flush_cnt decrements to 0 and saturates there.
  - flush = jump_flag | (flush_cnt != 0).
  - A new jump while flush_cnt != 0 reloads the counter.
- hold_flag and jump_flag are combinational from state and inputs. State, counters and the latched address are registered.
- ADDR_W arithmetic: no address arithmetic; addresses are passed through unchanged.

Optional Feature:
- Macro PIPE_CTRL_DRAIN_TIMEOUT_EN.
- Defined:
  - In DRAIN, when drain_cnt reaches DRAIN_MAX with a hold request still active, force REDIRECT on the next edge.
  - Set drain_timeout=1 on that edge; it stays sticky until reset.
- Undefined:
  - DRAIN waits indefinitely; drain_timeout is tied to 0.
  - drain_cnt logic is omitted.

Test Plan:
- Reset: rst_n low mid-DRAIN → all outputs 0 immediately; after release with no requests, hold_flag=0, flush=0.
- Hold priority: ex_hold_req=1 with bus_hold_req=1 → hold_flag=3; ex_hold_req=0 with bus_hold_req=1 → hold_flag=1; neither → 0.
- Execute jump: ex_jump_req=1, ex_jump_addr=0x0000_0100 for one cycle → same cycle jump_flag=1, jump_addr=0x100, flush=1; flush stays 1 for 2 further cycles, then 0.
- Trap with drain: trap_req=1, trap_addr=0x0000_0800 while ex_hold_req=1 for 3 cycles → hold_flag=3 for 3 DRAIN cycles, then jump_flag=1, jump_addr=0x800, trap_ack=1 for exactly 1 cycle, then flush for 2 cycles.
- Collision: ex_jump_req (0x200) and trap_req (0x800) in the same IDLE cycle → jump to 0x200 that cycle; ex_jump_req during DRAIN is ignored; REDIRECT to 0x800 two cycles later.
- Timeout (macro defined, DRAIN_MAX=4): trap_req with bus_hold_req stuck at 1 → REDIRECT after 4 DRAIN cycles; drain_timeout=1 and remains 1. Macro undefined → controller stays in DRAIN.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl - central pipeline sequencer.
// Purpose : drives the PC register's hold/jump inputs. It arbitrates stall
//           requests from execute and the bus and jump requests from execute
//           and the trap unit. It also sequences trap entry: accept, drain,
//           redirect, flush.
// Ports   : clk, rst_n       - clock, async active-low reset
//           ex_jump_req/addr - execute branch/jump and target
//           ex_hold_req      - multi-cycle execute op in progress
//           bus_hold_req     - bus wait state
//           trap_req/addr    - trap request (held until trap_ack) and handler
//           trap_ack         - one-cycle acknowledge, same cycle as redirect
//           hold_flag        - 0 none, 1 HOLD_PC, 2 HOLD_IF, 3 HOLD_ID
//           jump_flag/addr   - PC redirect and target
//           flush            - IF/ID contents invalid
//           drain_timeout    - sticky drain-timeout flag
// Config  : define PIPE_CTRL_DRAIN_TIMEOUT_EN to bound the drain phase to
//           DRAIN_MAX cycles; otherwise the drain waits indefinitely.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_MAX    = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_jump_req,
  input  logic [ADDR_W-1:0] ex_jump_addr,
  input  logic              ex_hold_req,
  input  logic              bus_hold_req,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_addr,
  output logic              trap_ack,
  output logic [2:0]        hold_flag,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              flush,
  output logic              drain_timeout
);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
    $error("pipe_ctrl: FLUSH_CYCLES must be within 1..7");
  end
  if (DRAIN_MAX < 1 || DRAIN_MAX > 255) begin : g_bad_drain_max
    $error("pipe_ctrl: DRAIN_MAX must be within 1..255");
  end

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0]   trap_addr_q, trap_addr_d;

  logic [2:0]          hold_c;
  logic                jump_c;
  logic [ADDR_W-1:0]   addr_c;
  logic                ack_c;

`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
  logic [7:0]          drain_cnt_q, drain_cnt_d;
  logic                drain_to_q, drain_to_d;
  logic                drain_last;

  // True on the drain cycle whose closing edge brings the count to DRAIN_MAX.
  assign drain_last = ({1'b0, drain_cnt_q} + 9'd1) >= 9'(DRAIN_MAX);
`endif

  always_comb begin
    state_d     = state_q;
    trap_addr_d = trap_addr_q;
    hold_c      = 3'd0;
    jump_c      = 1'b0;
    addr_c      = '0;
    ack_c       = 1'b0;
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
    drain_cnt_d = drain_cnt_q;
    drain_to_d  = drain_to_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (ex_hold_req)       hold_c = 3'd3;
        else if (bus_hold_req) hold_c = 3'd1;
        // The execute jump goes out now even if a trap is accepted in the same cycle.
        jump_c = ex_jump_req;
        addr_c = ex_jump_req ? ex_jump_addr : '0;
        if (trap_req) begin
          trap_addr_d = trap_addr;
          state_d     = ST_DRAIN;
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
          drain_cnt_d = 8'd0;
`endif
        end
      end
      ST_DRAIN: begin
        hold_c = 3'd3;
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
        if (drain_cnt_q != 8'hFF) drain_cnt_d = drain_cnt_q + 8'd1;
`endif
        if (!ex_hold_req && !bus_hold_req) begin
          state_d = ST_REDIRECT;
        end
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
        else if (drain_last) begin
          state_d    = ST_REDIRECT;
          drain_to_d = 1'b1;
        end
`endif
      end
      ST_REDIRECT: begin
        jump_c  = 1'b1;
        addr_c  = trap_addr_q;
        ack_c   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (jump_c)                 flush_cnt_d = 3'(FLUSH_CYCLES);
    else if (flush_cnt_q != '0) flush_cnt_d = flush_cnt_q - 3'd1;
    else                        flush_cnt_d = 3'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 3'd0;
      trap_addr_q <= '0;
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
      drain_cnt_q <= 8'd0;
      drain_to_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      trap_addr_q <= trap_addr_d;
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
      drain_cnt_q <= drain_cnt_d;
      drain_to_q  <= drain_to_d;
`endif
    end
  end

  // Outputs that depend on inputs are gated so that everything reads 0 during reset.
  assign hold_flag = rst_n ? hold_c : 3'd0;
  assign jump_flag = rst_n & jump_c;
  assign jump_addr = rst_n ? addr_c : '0;
  assign trap_ack  = rst_n & ack_c;
  assign flush     = rst_n & (jump_c | (flush_cnt_q != 3'd0));
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
  assign drain_timeout = drain_to_q;
`else
  assign drain_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl - randomized and directed bench for pipe_ctrl against a
// behavioural model of the sequencing rules.
module tb_pipe_ctrl;
  localparam int AW  = 32;
  localparam int FLC = 2;
  localparam int DMX = 4;
`ifdef PIPE_CTRL_DRAIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_jump_req, ex_hold_req, bus_hold_req, trap_req;
  logic [AW-1:0] ex_jump_addr, trap_addr;
  logic          trap_ack, jump_flag, flush, drain_timeout;
  logic [2:0]    hold_flag;
  logic [AW-1:0] jump_addr;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FLC), .DRAIN_MAX(DMX)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr),
    .ex_hold_req(ex_hold_req), .bus_hold_req(bus_hold_req),
    .trap_req(trap_req), .trap_addr(trap_addr),
    .trap_ack(trap_ack), .hold_flag(hold_flag),
    .jump_flag(jump_flag), .jump_addr(jump_addr),
    .flush(flush), .drain_timeout(drain_timeout)
  );

  always #5 clk = ~clk;

  // Model: is a trap being drained, is its redirect due now, how many
  // drain cycles have passed, how many flush cycles remain.
  bit            m_draining, m_redirect_due, m_timed_out;
  int            m_drained, m_flush_left;
  logic [AW-1:0] m_handler;
  bit            exp_ack;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_draining = 0; m_redirect_due = 0; m_timed_out = 0;
    m_drained = 0; m_flush_left = 0; m_handler = '0; exp_ack = 0;
  endtask

  // One clock cycle: drive, check combinational outputs mid-cycle, advance model at the edge.
  task automatic cyc(input bit eh, input bit bh, input bit ej, input logic [AW-1:0] ea,
                     input bit tr, input logic [AW-1:0] ta);
    logic [2:0]    e_hold;
    bit            e_jump;
    logic [AW-1:0] e_addr;
    ex_hold_req = eh; bus_hold_req = bh; ex_jump_req = ej; ex_jump_addr = ea;
    trap_req = tr; trap_addr = ta;
    if (m_redirect_due) begin
      e_hold = 3'd0; e_jump = 1; e_addr = m_handler; exp_ack = 1;
    end else if (m_draining) begin
      e_hold = 3'd3; e_jump = 0; e_addr = '0; exp_ack = 0;
    end else begin
      e_hold = eh ? 3'd3 : (bh ? 3'd1 : 3'd0);
      e_jump = ej; e_addr = ej ? ea : '0; exp_ack = 0;
    end
    #3;
    check("hold_flag", 64'(hold_flag), 64'(e_hold));
    check("jump_flag", 64'(jump_flag), 64'(e_jump));
    check("jump_addr", 64'(jump_addr), 64'(e_addr));
    check("trap_ack", 64'(trap_ack), 64'(exp_ack));
    check("flush", 64'(flush), 64'(e_jump || (m_flush_left > 0)));
    check("drain_timeout", 64'(drain_timeout), 64'(m_timed_out));
    @(posedge clk);
    m_flush_left = e_jump ? FLC : (m_flush_left > 0 ? m_flush_left - 1 : 0);
    if (m_redirect_due) begin
      m_redirect_due = 0;
    end else if (m_draining) begin
      m_drained++;
      if (!eh && !bh) begin
        m_draining = 0; m_redirect_due = 1;
      end else if (TO_EN && m_drained >= DMX) begin
        m_draining = 0; m_redirect_due = 1; m_timed_out = 1;
      end
    end else if (tr) begin
      m_draining = 1; m_drained = 0; m_handler = ta;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    bit            tr_on;
    logic [AW-1:0] tr_addr;
    rst_n = 1'b0;
    ex_hold_req = 1; bus_hold_req = 1; ex_jump_req = 1; ex_jump_addr = 32'h1234;
    trap_req = 1; trap_addr = 32'h5678;
    model_reset();
    #12;
    check("rst_hold", 64'(hold_flag), 64'd0);
    check("rst_jump", 64'(jump_flag), 64'd0);
    check("rst_flush", 64'(flush), 64'd0);
    check("rst_ack", 64'(trap_ack), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    // Hold priority
    cyc(1, 1, 0, '0, 0, '0);
    cyc(0, 1, 0, '0, 0, '0);
    cyc(1, 0, 0, '0, 0, '0);
    cyc(0, 0, 0, '0, 0, '0);

    // Execute jump then flush tail
    cyc(0, 0, 1, 32'h100, 0, '0);
    idle(4);

    // Trap with a 3-cycle execute hold
    cyc(1, 0, 0, '0, 1, 32'h800);
    cyc(1, 0, 0, '0, 1, 32'h800);
    cyc(1, 0, 0, '0, 1, 32'h800);
    cyc(0, 0, 0, '0, 1, 32'h800);
    cyc(0, 0, 0, '0, 1, 32'h800);
    idle(4);

    // Collision: execute jump wins this cycle, trap redirects two cycles later
    cyc(0, 0, 1, 32'h200, 1, 32'h800);
    cyc(0, 0, 1, 32'h300, 1, 32'h800);
    cyc(0, 0, 1, 32'h400, 1, 32'h800);
    idle(4);

    // Back-to-back: trap_req still high in the IDLE cycle after the ack
    cyc(0, 0, 0, '0, 1, 32'hA00);
    cyc(0, 0, 0, '0, 1, 32'hA00);
    cyc(0, 0, 0, '0, 1, 32'hA00);
    cyc(0, 0, 0, '0, 1, 32'hB00);
    idle(5);

    // Bus hold stuck during drain: timeout build redirects, default build keeps draining
    tr_on = 1;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 1, 1, 32'h40, tr_on, 32'hC00);
      if (exp_ack) tr_on = 0;
    end
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, tr_on, 32'hC00);
      if (exp_ack) tr_on = 0;
    end
    idle(4);

    // Reset asserted mid-drain, away from the clock edge
    cyc(0, 0, 0, '0, 1, 32'hD00);
    ex_hold_req = 1; ex_jump_req = 1; ex_jump_addr = 32'h44;
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_hold", 64'(hold_flag), 64'd0);
    check("rst_mid_jump", 64'(jump_flag), 64'd0);
    check("rst_mid_addr", 64'(jump_addr), 64'd0);
    check("rst_mid_flush", 64'(flush), 64'd0);
    check("rst_mid_to", 64'(drain_timeout), 64'd0);
    model_reset();
    @(posedge clk); #1;
    trap_req = 0; ex_hold_req = 0; ex_jump_req = 0;
    rst_n = 1'b1;
    idle(3);

    // Randomized traffic; trap_req held until acknowledged
    tr_on = 0; tr_addr = '0;
    for (int i = 0; i < 600; i++) begin
      if (!tr_on && $urandom_range(0, 5) == 0) begin
        tr_on = 1; tr_addr = $urandom;
      end
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 4) == 0, $urandom, tr_on, tr_addr);
      if (exp_ack) tr_on = 0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
